// File: rtl/srt_div_scheduler_pkg.sv
// Shared types and defaults for the SRT divider scheduler and its divider core.
package srt_div_scheduler_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 8;
  localparam int unsigned DIV_LATENCY_DEF = 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  // Number of radix-4 digit iterations needed for a w-bit quotient.
  function automatic int unsigned div_iters(input int unsigned w);
    return (w + 1) / 2;
  endfunction

endpackage

// File: rtl/srt_div_scheduler_div_core.sv
// Radix-4 digit-recurrence divider core: two quotient bits per cycle.
// The enable pulse loads the operands; results are stable div_iters(DATA_WIDTH)
// cycles after the enable edge and are held until the next enable.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   en                    one-cycle start pulse
//   dividend, divisor     operands sampled on en
//   quotient, remainder   registered results
//   ov_flag               registered divide-by-zero flag
module srt_div_scheduler_div_core
  import srt_div_scheduler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  ov_flag
);

  localparam int unsigned ITERS = div_iters(DATA_WIDTH);
  localparam int unsigned PW    = 2 * ITERS;
  localparam int unsigned IW    = $clog2(ITERS + 1);
  localparam int unsigned RW    = DATA_WIDTH + 2;

  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] dvs_q, dvs_d;
  logic [PW-1:0]         acc_q, acc_d;
  logic [IW-1:0]         iter_q, iter_d;
  logic                  ov_q, ov_d;

  logic [RW-1:0]         r4, d1, d2, d3, r_sel;
  logic [1:0]            digit;

  // Digit selection: largest multiple of the divisor not exceeding the shifted remainder.
  // acc_q shifts dividend bits out the top while quotient digits enter the bottom.
  always_comb begin
    r4     = {rem_q, acc_q[PW-1 -: 2]};
    d1     = RW'(dvs_q);
    d2     = d1 << 1;
    d3     = d1 + d2;
    digit  = 2'd0;
    r_sel  = r4;
    if (r4 >= d3) begin
      digit = 2'd3;
      r_sel = r4 - d3;
    end else if (r4 >= d2) begin
      digit = 2'd2;
      r_sel = r4 - d2;
    end else if (r4 >= d1) begin
      digit = 2'd1;
      r_sel = r4 - d1;
    end

    rem_d  = rem_q;
    dvs_d  = dvs_q;
    acc_d  = acc_q;
    iter_d = iter_q;
    ov_d   = ov_q;
    if (en) begin
      rem_d  = '0;
      acc_d  = PW'(dividend);
      dvs_d  = divisor;
      iter_d = IW'(ITERS);
      ov_d   = (divisor == '0);
    end else if (iter_q != '0) begin
      rem_d  = DATA_WIDTH'(r_sel);
      acc_d  = {acc_q[PW-3:0], digit};
      iter_d = iter_q - IW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      acc_q  <= '0;
      iter_q <= '0;
      ov_q   <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      acc_q  <= acc_d;
      iter_q <= iter_d;
      ov_q   <= ov_d;
    end
  end

  assign quotient  = acc_q[DATA_WIDTH-1:0];
  assign remainder = rem_q;
  assign ov_flag   = ov_q;

endmodule

// File: rtl/srt_div_scheduler.sv
// Round-robin scheduler sharing one divider core among N_REQ requesters.
// One operation in flight: accept -> launch -> wait DIV_LATENCY -> hold response.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   req_valid/req_ready          per-requester request handshake (req_ready combinational)
//   req_dividend/req_divisor     packed operands, requester i at slice i
//   rsp_valid/rsp_ready          per-requester response handshake
//   rsp_quotient/remainder/ov    held result of the current response
//   busy                         high whenever not idle
module srt_div_scheduler
  import srt_div_scheduler_pkg::*;
#(
  parameter int unsigned N_REQ       = 4,
  parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned DIV_LATENCY = DIV_LATENCY_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req_valid,
  output logic [N_REQ-1:0]            req_ready,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_dividend,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_divisor,
  output logic [N_REQ-1:0]            rsp_valid,
  input  logic [N_REQ-1:0]            rsp_ready,
  output logic [DATA_WIDTH-1:0]       rsp_quotient,
  output logic [DATA_WIDTH-1:0]       rsp_remainder,
  output logic                        rsp_ov_flag,
  output logic                        busy
);

  localparam int unsigned GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW = (DIV_LATENCY > 1) ? $clog2(DIV_LATENCY) : 1;

  state_e                  state_q, state_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;
  logic [GW-1:0]           grant_q, grant_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   dvd_q, dvd_d, dvs_q, dvs_d;
  logic [DATA_WIDTH-1:0]   quot_q, quot_d, rem_q, rem_d;
  logic                    ov_q, ov_d;
  logic                    core_en_q, core_en_d;
  logic                    busy_q, busy_d;
  logic [N_REQ-1:0]        rsp_valid_q, rsp_valid_d;

  logic                    rr_found;
  logic [GW-1:0]           rr_idx, rr_cand;
  logic [DATA_WIDTH-1:0]   core_quot, core_rem;
  logic                    core_ov;

  // Round-robin search starting one past the last accepted requester.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      rr_cand = GW'((32'(last_grant_q) + k) % N_REQ);
      if (!rr_found && req_valid[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  assign req_ready = (state_q == S_IDLE && rr_found) ? (N_REQ'(1) << rr_idx) : '0;

  // Next-state and datapath updates.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;
    dvd_d        = dvd_q;
    dvs_d        = dvs_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    ov_d         = ov_q;
    core_en_d    = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          state_d      = S_LAUNCH;
          last_grant_d = rr_idx;
          grant_d      = rr_idx;
          dvd_d        = req_dividend[32'(rr_idx) * DATA_WIDTH +: DATA_WIDTH];
          dvs_d        = req_divisor[32'(rr_idx) * DATA_WIDTH +: DATA_WIDTH];
          core_en_d    = 1'b1;
        end
      end
      S_LAUNCH: begin
        cnt_d   = CW'(DIV_LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          quot_d      = core_quot;
          rem_d       = core_rem;
          ov_d        = core_ov;
          rsp_valid_d = N_REQ'(1) << grant_q;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready[grant_q]) begin
          rsp_valid_d = '0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= GW'(N_REQ - 1);
      grant_q      <= '0;
      cnt_q        <= '0;
      dvd_q        <= '0;
      dvs_q        <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
      ov_q         <= 1'b0;
      core_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      rsp_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      dvd_q        <= dvd_d;
      dvs_q        <= dvs_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
      ov_q         <= ov_d;
      core_en_q    <= core_en_d;
      busy_q       <= busy_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  srt_div_scheduler_div_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_div_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .en        (core_en_q),
    .dividend  (dvd_q),
    .divisor   (dvs_q),
    .quotient  (core_quot),
    .remainder (core_rem),
    .ov_flag   (core_ov)
  );

  assign rsp_valid     = rsp_valid_q;
  assign rsp_quotient  = quot_q;
  assign rsp_remainder = rem_q;
  assign rsp_ov_flag   = ov_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_srt_div_scheduler.sv
// Directed bench for srt_div_scheduler (N_REQ=4, DATA_WIDTH=8, DIV_LATENCY=8).
module tb_srt_div_scheduler;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int LAT = 8;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_dividend;
  logic [N*DW-1:0] req_divisor;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [DW-1:0]   rsp_quotient;
  logic [DW-1:0]   rsp_remainder;
  logic            rsp_ov_flag;
  logic            busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [7:0] rr_dvd [4] = '{8'd13, 8'd23, 8'd33, 8'd43};
  logic [7:0] rr_dvs [4] = '{8'd2,  8'd3,  8'd4,  8'd5};
  logic [7:0] rr_q   [4] = '{8'd6,  8'd7,  8'd8,  8'd8};
  logic [7:0] rr_r   [4] = '{8'd1,  8'd2,  8'd1,  8'd3};

  srt_div_scheduler #(
    .N_REQ       (N),
    .DATA_WIDTH  (DW),
    .DIV_LATENCY (LAT)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_ov_flag   (rsp_ov_flag),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] dvd, input logic [7:0] dvs);
    req_dividend[i*DW +: DW] = dvd;
    req_divisor[i*DW +: DW]  = dvs;
  endtask

  // Steps negedges until a response appears (bounded); lat counts cycles since accept.
  task automatic wait_rsp(output int lat, input bit drop);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (drop && lat == 1) req_valid = '0;
    end while (rsp_valid == '0 && lat < 100);
  endtask

  task automatic consume(input int i);
    rsp_ready = 4'(1 << i);
    @(negedge clk);
    chk("consume_rsp_valid", 32'(rsp_valid), 0);
    chk("consume_busy", 32'(busy), 0);
    rsp_ready = '0;
  endtask

  task automatic run_single(input int i, input logic [7:0] dvd, input logic [7:0] dvs,
                            input logic [7:0] q, input logic [7:0] r, input bit ov,
                            input bit chk_qr, input bit do_consume);
    int lat;
    set_req(i, dvd, dvs);
    req_valid = 4'(1 << i);
    #1;
    chk("single_req_ready", 32'(req_ready), 32'(1 << i));
    wait_rsp(lat, 1'b1);
    chk("single_latency", 32'(lat), LAT + 2);
    chk("single_rsp_valid", 32'(rsp_valid), 32'(1 << i));
    chk("single_ov", 32'(rsp_ov_flag), 32'(ov));
    chk("single_busy", 32'(busy), 1);
    if (chk_qr) begin
      chk("single_quotient", 32'(rsp_quotient), 32'(q));
      chk("single_remainder", 32'(rsp_remainder), 32'(r));
    end
    if (do_consume) consume(i);
  endtask

  initial begin
    int lat;
    int prev_cyc;
    int n;
    reset_n      = 1'b0;
    req_valid    = '0;
    rsp_ready    = '0;
    req_dividend = '0;
    req_divisor  = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_quotient", 32'(rsp_quotient), 0);
    chk("rst_remainder", 32'(rsp_remainder), 0);
    chk("rst_ov", 32'(rsp_ov_flag), 0);
    chk("rst_busy", 32'(busy), 0);
    reset_n = 1'b1;
    @(negedge clk);

    // 100/7 from requester 2, then boundary operands and divide-by-zero
    run_single(2, 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 1'b1, 1'b1);
    run_single(3, 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b1, 1'b1);
    run_single(0, 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, 1'b1, 1'b1);
    run_single(1, 8'd77, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, 1'b1);

    // Response held 20 cycles with noise on other rsp_ready bits and all req_valid
    run_single(2, 8'd200, 8'd13, 8'd15, 8'd5, 1'b0, 1'b1, 1'b0);
    rsp_ready = 4'b1011;
    req_valid = 4'b1111;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("hold_rsp_valid", 32'(rsp_valid), 32'h4);
      chk("hold_quotient", 32'(rsp_quotient), 15);
      chk("hold_remainder", 32'(rsp_remainder), 5);
      chk("hold_req_ready", 32'(req_ready), 0);
    end
    req_valid = '0;
    rsp_ready = '0;
    consume(2);

    run_single(3, 8'd50, 8'd9, 8'd5, 8'd5, 1'b0, 1'b1, 1'b1);

    // All requesters continuously valid, rsp_ready high: grants 0,1,2,3,0
    for (int i = 0; i < N; i++) set_req(i, rr_dvd[i], rr_dvs[i]);
    rsp_ready = 4'b1111;
    req_valid = 4'b1111;
    #1;
    prev_cyc = 0;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (req_ready == '0 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("rr_grant", 32'(req_ready), 32'(1 << (g % N)));
      if (g > 0) chk("rr_gap", 32'(cyc - prev_cyc), LAT + 3);
      prev_cyc = cyc;
      wait_rsp(lat, 1'b0);
      chk("rr_latency", 32'(lat), LAT + 2);
      chk("rr_rsp_valid", 32'(rsp_valid), 32'(1 << (g % N)));
      chk("rr_quotient", 32'(rsp_quotient), 32'(rr_q[g % N]));
      chk("rr_remainder", 32'(rsp_remainder), 32'(rr_r[g % N]));
    end
    req_valid = '0;
    @(negedge clk);
    rsp_ready = '0;

    // Reset during the wait phase abandons the operation
    set_req(1, 8'd90, 8'd9);
    req_valid = 4'b0010;
    #1;
    chk("abort_req_ready", 32'(req_ready), 32'h2);
    @(negedge clk);
    req_valid = '0;
    repeat (4) @(negedge clk);
    chk("abort_busy_before", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 0);
    chk("abort_req_ready0", 32'(req_ready), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_quotient", 32'(rsp_quotient), 0);
    chk("abort_remainder", 32'(rsp_remainder), 0);
    chk("abort_ov", 32'(rsp_ov_flag), 0);
    @(negedge clk);
    chk("abort_rsp_valid_next", 32'(rsp_valid), 0);
    reset_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 0);
    end
    for (int i = 0; i < N; i++) set_req(i, rr_dvd[i], rr_dvs[i]);
    req_valid = 4'b1111;
    #1;
    chk("post_rst_grant", 32'(req_ready), 32'h1);
    wait_rsp(lat, 1'b1);
    chk("post_rst_latency", 32'(lat), LAT + 2);
    chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("post_rst_quotient", 32'(rsp_quotient), 32'(rr_q[0]));
    chk("post_rst_remainder", 32'(rsp_remainder), 32'(rr_r[0]));
    consume(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/srt_div_scheduler.md
SRT_DIV_SCHEDULER -- requirements
Module: srt_div_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, operand width; must match the shared divider core.
REQ-003 SHALL have parameter DIV_LATENCY, default 8, cycles from core enable pulse to valid core quotient/remainder/ov_flag.
REQ-004 SHALL have port clk  in  1  clock.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  in  N_REQ  per-requester request valid.
REQ-007 SHALL have port req_ready  out  N_REQ  per-requester request accepted (one-hot or zero).
REQ-008 SHALL have port req_dividend  in  N_REQ*DATA_WIDTH  packed dividends, requester i at slice i.
REQ-009 SHALL have port req_divisor  in  N_REQ*DATA_WIDTH  packed divisors.
REQ-010 SHALL have port rsp_valid  out  N_REQ  per-requester result valid.
REQ-011 SHALL have port rsp_ready  in  N_REQ  per-requester result consumed.
REQ-012 SHALL have port rsp_quotient  out  DATA_WIDTH  quotient of the held result.
REQ-013 SHALL have port rsp_remainder  out  DATA_WIDTH  remainder of the held result.
REQ-014 SHALL have port rsp_ov_flag  out  1  divide-by-zero flag of the held result.
REQ-015 SHALL have port busy  out  1  high in any state other than S_IDLE.

Function
REQ-016 SHALL implement FSM states S_IDLE, S_LAUNCH, S_WAIT, S_RESP.
REQ-017 S_IDLE: when any req_valid is high, grant exactly one requester round-robin starting at last_grant+1 (wrapping N_REQ-1 to 0), assert its req_ready for that one cycle, latch operands and grant index, go to S_LAUNCH.
REQ-018 S_LAUNCH: drive core enable for exactly one cycle with latched operands, load latency counter with DIV_LATENCY-1, go to S_WAIT.
REQ-019 S_WAIT: decrement counter each cycle; when counter reaches 0, capture core quotient, remainder and ov_flag into result registers and go to S_RESP.
REQ-020 S_RESP: assert rsp_valid only on the bit of the latched grant index; hold result outputs stable until rsp_ready on that bit, then return to S_IDLE.
REQ-021 rsp_ready on non-granted bits SHALL be ignored; req_valid changes during non-IDLE states SHALL be ignored.
REQ-022 Request-to-response latency SHALL be DIV_LATENCY+2 cycles (accept cycle to first rsp_valid cycle); back-to-back throughput one operation per DIV_LATENCY+3 cycles with rsp_ready tied high.
REQ-023 last_grant SHALL update only on acceptance; the fairness pointer SHALL make any continuously requesting requester wait at most N_REQ-1 operations.
REQ-024 Divisor zero SHALL still pass through the core; result reports rsp_ov_flag=1, and quotient/remainder are whatever the core produces and SHALL NOT be checked.
REQ-025 req_ready SHALL be asserted only in S_IDLE; never more than one bit high.

Reset
REQ-026 On reset_n low, state SHALL become S_IDLE, last_grant SHALL become N_REQ-1 (so requester 0 wins first), counter 0.
REQ-027 Reset values: req_ready 0, rsp_valid 0, rsp_quotient 0, rsp_remainder 0, rsp_ov_flag 0, busy 0, core enable 0.
REQ-028 Reset mid-operation SHALL abandon the operation with no response; the requester must re-request.

Structure
REQ-029 A shared package SHALL hold the state enum type and the default DATA_WIDTH/DIV_LATENCY constants.
REQ-030 Exactly one sub-module SHALL be instanced: the radix-4 SRT division core, named u_div_core.
REQ-031 Round-robin grant SHALL be combinational from req_valid and last_grant; all outputs registered except req_ready.

Verification
REQ-032 Single request: requester 2, 100/7 -> rsp_valid[2] at accept+DIV_LATENCY+2, quotient 14, remainder 2, ov 0.
REQ-033 All four req_valid high continuously, rsp_ready high -> grants in order 0,1,2,3,0; each gap DIV_LATENCY+3 cycles.
REQ-034 Divisor 0 from requester 1 -> rsp_valid[1] with rsp_ov_flag 1.
REQ-035 rsp_ready held low 20 cycles in S_RESP -> outputs stable, req_ready stays 0, rsp_ready on other bits ignored.
REQ-036 reset_n pulsed low during S_WAIT -> all outputs 0 next cycle, no rsp_valid; next request granted to requester 0.
REQ-037 255/1 and 255/255 -> quotient 255 remainder 0, quotient 1 remainder 0.
